mk8_dual_port_program_memory: RTL
=================================

// Module: mk8_dual_port_program_memory
// PURPOSE
//  Parametrised true-dual-port on-chip memory with two Avalon-MM slaves:
//  s1 for CPU data/loader access, s2 for instruction fetch. Supports per-byte
//  writes and a fixed, selectable read latency with readdatavalid. An optional
//  post-reset zero-fill sequencer clears the memory. Replaces the fixed
//  4096x32 single-port program memory in the Mk8 CPU subsystems.
// PARAMETERS
//  DATA_WIDTH      32   word width, multiple of 8
//  ADDR_WIDTH      12   word address width; DEPTH = 2**ADDR_WIDTH
//  READ_LATENCY    1    1 = array-registered read; 2 = extra output register
//  CLEAR_ON_RESET  1    1 = zero-fill all words after reset; 0 = no clear
// PORTS
//  clk              in   1            single clock, all logic rising-edge
//  reset_n          in   1            asynchronous, active-low reset
//  reset_req        in   1            stall: no accepts, pipelines and FSM hold
//  s1_address       in   ADDR_WIDTH   word address
//  s1_chipselect    in   1            slave select
//  s1_read          in   1            read request
//  s1_write         in   1            write request
//  s1_byteenable    in   DATA_WIDTH/8 byte lane enables
//  s1_writedata     in   DATA_WIDTH   write data
//  s1_readdata      out  DATA_WIDTH   read data, valid with s1_readdatavalid
//  s1_readdatavalid out  1            one-cycle pulse per accepted read
//  s1_waitrequest   out  1            command not accepted this cycle
//  s2_*             --   --           same set and meaning as s1_*
//  init_done        out  1            high once memory is ready for access
// BEHAVIOUR
//  Reset values: readdata 0, readdatavalid 0, waitrequest 1, init_done 0,
//  FSM = INIT, clear counter 0. Memory contents are not reset.
//  FSM transitions:
//   INIT -> CLEAR on the first clk with reset_n high and reset_req low,
//   when CLEAR_ON_RESET=1; otherwise INIT -> READY.
//   CLEAR: writes all-zero to word clr_addr, then clr_addr++.
//   CLEAR -> READY after word DEPTH-1 is written (DEPTH cycles in CLEAR).
//  init_done = (state==READY). It is high the cycle after the last clear write.
//  waitrequest = ~init_done | reset_req on both ports.
//  Accept: chipselect & (read|write) & ~waitrequest.
//  Write: for each lane b with byteenable[b]=1, byte b of the word is updated
//   at the accepting edge. Lanes with byteenable[b]=0 are unchanged.
//  Read: readdata is valid READ_LATENCY cycles after the accepting edge.
//   readdatavalid pulses for exactly that one cycle.
//   readdata holds its last value while readdatavalid=0.
//  read & write together: the write is performed, the read is ignored, and
//   no readdatavalid is generated.
//  Back-to-back reads: one per cycle per port, fully pipelined, in order.
//  Cross-port collisions in the same cycle, same address:
//   - write on one port + read on the other: read returns old data.
//   - both ports write: per lane, s1 wins where s1_byteenable is set; s2
//     lanes not enabled on s1 are written from s2.
//  reset_req high: no new accepts. Read pipeline registers, readdatavalid
//   shift stages, clr_addr and FSM state all hold. Nothing is dropped.
//  reset_n low mid-operation: in-flight reads are discarded (readdatavalid 0).
//   With CLEAR_ON_RESET=1 the clear restarts from word 0.
// TESTING
//  1 CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset -> waitrequest stays 1 for
//    17 cycles, init_done rises; read all 16 words -> all 0x00000000.
//  2 s1 write 0xDEADBEEF @5 be=4'hF, then write 0x00001200 @5 be=4'b0010;
//    s2 read @5 -> 0xDEAD12EF, with readdatavalid exactly READ_LATENCY
//    cycles later (test 1 and 2).
//  3 Same cycle: s1 write 0x11111111 be=4'h3 and s2 write 0x22222222 be=4'hF
//    @9 -> word 9 = 0x22221111. Same cycle: s1 write @3 and s2 read @3 ->
//    s2 returns the prior contents of word 3.
//  4 s2 issues 4 back-to-back reads @0..3; reset_req is high for 3 cycles
//    mid-stream -> 4 readdatavalid pulses, in order, data correct,
//    waitrequest=1 during the stall.
//  5 reset_n pulsed low at clear word 7 -> outputs return to reset values;
//    clear restarts at 0; full DEPTH+1-cycle sequence observed.
//  6 CLEAR_ON_RESET=0 -> init_done high 1 cycle after reset release.

Source files
------------

// File: rtl/mk8_dual_port_program_memory.sv
// True-dual-port program memory with two Avalon-MM slaves (s1 data/loader, s2 fetch),
// byte-lane writes, fixed read latency of 1 or 2, and an optional post-reset zero-fill.
module mk8_dual_port_program_memory #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    reset_req,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,

    output logic                    init_done
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit TWO_STAGE = (READ_LATENCY == 2);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clear_we;
    logic                    waitrequest;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Per-port views of the two slaves, index 0 = s1, index 1 = s2.
    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [NUM_LANES-1:0]    be    [2];
    logic [DATA_WIDTH-1:0]   wdata [2];
    logic [1:0]              wr_acc;
    logic [1:0]              rd_acc;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    assign init_done      = (state == ST_READY);
    assign waitrequest    = ~init_done | reset_req;
    assign s1_waitrequest = waitrequest;
    assign s2_waitrequest = waitrequest;

    // A combined read+write is treated as a write only.
    assign wr_acc[0] = s1_chipselect & s1_write & ~waitrequest;
    assign wr_acc[1] = s2_chipselect & s2_write & ~waitrequest;
    assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~waitrequest;
    assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~waitrequest;

    assign clear_we = (state == ST_CLEAR) & ~reset_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else if (!reset_req) begin
            case (state)
                ST_INIT: state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) state <= ST_READY;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array itself has no reset; the clear sequencer zeroes it, which keeps
    // it mappable onto block RAM. s2 lanes are written first so s1 lanes win on collision.
    always_ff @(posedge clk) begin
        if (clear_we) mem[clr_addr] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (wr_acc[p]) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (be[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  rd_valid_q;
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  out_valid;
        logic [DATA_WIDTH-1:0] out_data;

        // Stage 1 is the array read register; it only holds during a stall when a
        // second stage follows it, otherwise it is the output pulse itself.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else begin
                if (!(TWO_STAGE && reset_req)) rd_valid_q <= rd_acc[p];
                if (rd_acc[p]) rd_data_q <= mem[addr[p]];
            end
        end

        if (TWO_STAGE) begin : g_out_reg
            logic                  out_valid_q;
            logic [DATA_WIDTH-1:0] out_data_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= rd_valid_q & ~reset_req;
                    if (rd_valid_q && !reset_req) out_data_q <= rd_data_q;
                end
            end

            assign out_valid = out_valid_q;
            assign out_data  = out_data_q;
        end else begin : g_no_out_reg
            assign out_valid = rd_valid_q;
            assign out_data  = rd_data_q;
        end
    end

    assign s1_readdata      = g_port[0].out_data;
    assign s1_readdatavalid = g_port[0].out_valid;
    assign s2_readdata      = g_port[1].out_data;
    assign s2_readdatavalid = g_port[1].out_valid;

endmodule
